shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-step shift/rotate sequencer around an external 1-bit shift unit.
// Captures operand, op and step count on start, iterates the external unit
// once per cycle, then registers result/cout/zero and pulses done.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one single-bit step per cycle through the external unit
// DONE  | results valid, done pulsed for one cycle, back to IDLE
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] sh_a,
  output logic             sh_s3,
  output logic             sh_s2,
  input  logic [WIDTH-1:0] sh_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] work;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] cnt;
  logic             cout_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_q;
  logic             zero_q;
  logic             step_bit;
  logic             accept;
  logic             last_step;

  // Bit leaving the work register this step: MSB for left ops, LSB for right ops.
  assign step_bit  = op_r[0] ? work[0] : work[WIDTH-1];
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == AMT_W'(1));

  assign sh_a   = work;
  assign sh_s3  = op_r[1];
  assign sh_s2  = op_r[0];
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_r;
  assign cout   = cout_q;
  assign zero   = zero_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-step iteration through the external unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      op_r   <= '0;
      cnt    <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      work   <= A;
      op_r   <= op;
      cnt    <= amt;
      cout_r <= 1'b0;
    end else if (state == SHIFT) begin
      work   <= sh_out;
      cnt    <= cnt - AMT_W'(1);
      cout_r <= step_bit;
    end
  end

  // Result registers, loaded only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else if (accept && (amt == '0)) begin
      result_r <= A;
      cout_q   <= 1'b0;
      zero_q   <= (A == '0);
    end else if (last_step) begin
      // The final step's value and out-bit are taken directly, since work and
      // cout_r only catch up on this same edge.
      result_r <= sh_out;
      cout_q   <= step_bit;
      zero_q   <= (sh_out == '0);
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 1-bit shift unit.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [1:0] op;
  logic [2:0] amt;
  logic [7:0] sh_a;
  logic       sh_s3;
  logic       sh_s2;
  logic [7:0] sh_out;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       zero;

  int n_vec = 0;
  int n_bad = 0;

  shift_seq_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (a_in),
    .op     (op),
    .amt    (amt),
    .sh_a   (sh_a),
    .sh_s3  (sh_s3),
    .sh_s2  (sh_s2),
    .sh_out (sh_out),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External single-step shift/rotate unit.
  always_comb begin
    sh_out = 8'h00;
    case ({sh_s3, sh_s2})
      2'b00: sh_out = {sh_a[6:0], 1'b0};
      2'b01: sh_out = {1'b0, sh_a[7:1]};
      2'b10: sh_out = {sh_a[6:0], sh_a[7]};
      2'b11: sh_out = {sh_a[0], sh_a[7:1]};
      default: sh_out = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; start is accepted on the next posedge.
  task automatic run_op(input logic [7:0] a, input logic [1:0] o, input logic [2:0] n,
                        input logic [7:0] exp_res, input logic exp_cout, input logic exp_zero,
                        input int exp_lat, input bit inject);
    int lat;
    start = 1'b1;
    a_in  = a;
    op    = o;
    amt   = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;
    op    = ~o;
    amt   = ~n;
    lat   = 1;
    while (!done && lat < 12) begin
      chk("sel_stable", {30'd0, sh_s3, sh_s2}, {30'd0, o});
      chk("busy_in_op", {31'd0, busy}, 32'd1);
      if (inject && lat == 1) begin
        start = 1'b1;
        a_in  = 8'hFF;
        op    = 2'b11;
        amt   = 3'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk("latency",  lat, exp_lat);
    chk("done",     {31'd0, done}, 32'd1);
    chk("sel_done", {30'd0, sh_s3, sh_s2}, {30'd0, o});
    chk("result",   {24'd0, result}, {24'd0, exp_res});
    chk("cout",     {31'd0, cout}, {31'd0, exp_cout});
    chk("zero",     {31'd0, zero}, {31'd0, exp_zero});
    @(posedge clk);
    #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy",  {31'd0, busy}, 32'd0);
    chk("result_hold", {24'd0, result}, {24'd0, exp_res});
  endtask

  initial begin
    int seen_done;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    op    = 2'b00;
    amt   = 3'd0;
    #3;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_cout",   {31'd0, cout}, 32'd0);
    chk("rst_zero",   {31'd0, zero}, 32'd1);
    chk("rst_sh_a",   {24'd0, sh_a}, 32'd0);
    chk("rst_sel",    {30'd0, sh_s3, sh_s2}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First start accepted on the first edge after reset release.
    run_op(8'h96, 2'b00, 3'd3, 8'hB0, 1'b0, 1'b0, 4, 1'b0);
    // Back-to-back: started in the idle cycle right after done.
    run_op(8'h01, 2'b11, 3'd1, 8'h80, 1'b1, 1'b0, 2, 1'b0);
    run_op(8'h81, 2'b10, 3'd7, 8'hC0, 1'b0, 1'b0, 8, 1'b0);
    run_op(8'h80, 2'b00, 3'd1, 8'h00, 1'b1, 1'b1, 2, 1'b0);
    run_op(8'h5A, 2'b01, 3'd0, 8'h5A, 1'b0, 1'b0, 1, 1'b0);
    run_op(8'h5A, 2'b10, 3'd0, 8'h5A, 1'b0, 1'b0, 1, 1'b0);
    run_op(8'h96, 2'b01, 3'd2, 8'h25, 1'b1, 1'b0, 3, 1'b0);
    // Start with A=FF while busy must be ignored.
    run_op(8'h96, 2'b00, 3'd3, 8'hB0, 1'b0, 1'b0, 4, 1'b1);
    run_op(8'h01, 2'b11, 3'd1, 8'h80, 1'b1, 1'b0, 2, 1'b0);

    // Asynchronous reset two steps into a five-step right shift.
    start = 1'b1;
    a_in  = 8'h0F;
    op    = 2'b01;
    amt   = 3'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_sh_a", {24'd0, sh_a}, 32'h03);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",   {31'd0, busy}, 32'd0);
    chk("arst_done",   {31'd0, done}, 32'd0);
    chk("arst_result", {24'd0, result}, 32'd0);
    chk("arst_zero",   {31'd0, zero}, 32'd1);
    chk("arst_sh_a",   {24'd0, sh_a}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) rst = 1'b0;
      if (done) seen_done++;
    end
    chk("arst_no_done", seen_done, 0);
    chk("arst_result_after", {24'd0, result}, 32'd0);

    run_op(8'h0F, 2'b01, 3'd5, 8'h00, 1'b0, 1'b1, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, limit 20000");
    $fatal(1, "timeout");
  end

endmodule
